// File: rtl/kstep_spi_host_if.sv
// Host-side bundle for the kstep SPI initiator: request/response handshake
// plus the four SPI wires and a debug view of the sequencer state.
//
// Handshake: the requester raises start with tx_frame valid; the host accepts
// it only while idle (busy low), copying tx_frame on that edge, after which
// tx_frame may change. busy stays high until the host is idle again; done
// pulses for one cycle when rx_frame becomes valid. start seen while busy is
// dropped, never queued.
interface kstep_spi_host_if #(
  parameter int FRAME_BYTES = 4
);
  localparam int B = 8 * FRAME_BYTES;

  logic         start;
  logic [B-1:0] tx_frame;
  logic [B-1:0] rx_frame;
  logic         busy;
  logic         done;
  logic         spi_cs_n;
  logic         spi_sclk;
  logic         spi_mosi;
  logic         spi_miso;
  logic [2:0]   state_dbg;

  // Requester / SPI-target side: drives the request and miso.
  modport master (
    output start, tx_frame, spi_miso,
    input  rx_frame, busy, done, spi_cs_n, spi_sclk, spi_mosi, state_dbg
  );

  // The SPI host itself.
  modport slave (
    input  start, tx_frame, spi_miso,
    output rx_frame, busy, done, spi_cs_n, spi_sclk, spi_mosi, state_dbg
  );
endinterface

// File: rtl/kstep_spi_host.sv
// SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first, active-low CS) sending one
// fixed-length full-duplex frame per request. Every phase lasts CLK_DIV
// clocks; HOLD lasts two such phases: the closing SCLK-low half-period of the
// last bit followed by the CS hold time.
module kstep_spi_host #(
  parameter int CLK_DIV     = 4,
  parameter int FRAME_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  kstep_spi_host_if.slave bus
);
  localparam int              B        = 8 * FRAME_BYTES;
  localparam int              BW       = $clog2(B) + 1;
  localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0]   BITS     = BW'(B);
  localparam logic [BW-1:0]   BITS_P1  = BW'(B + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [B-1:0]  tx_shift_q, tx_shift_d;
  logic [B-1:0]  rx_shift_q, rx_shift_d;
  logic [B-1:0]  rx_frame_q, rx_frame_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          div_end;

  // Last clock of the current phase.
  assign div_end = (div_cnt_q == DIV_LAST);

  // State register and all datapath flops; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_frame_q <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_frame_q <= rx_frame_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state: each timed phase advances on its last clock.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_SETUP;
      S_SETUP: if (div_end)   state_d = S_HIGH;
      S_HIGH:  if (div_end)   state_d = (bit_cnt_q == BITS) ? S_HOLD : S_LOW;
      S_LOW:   if (div_end)   state_d = S_HIGH;
      // bit_cnt moves past BITS once the trailing low half-period is over.
      S_HOLD:  if (div_end && (bit_cnt_q != BITS)) state_d = S_GAP;
      S_GAP:   if (div_end)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and pin updates tied to the phase transitions.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_frame_d = rx_frame_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != S_IDLE) begin
      div_cnt_d = div_end ? 8'd0 : div_cnt_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tx_shift_d = bus.tx_frame;
          mosi_d     = bus.tx_frame[B-1];
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          div_cnt_d  = 8'd0;
        end
      end
      S_SETUP, S_LOW: begin
        if (div_end) begin
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[B-2:0], bus.spi_miso};
          bit_cnt_d  = bit_cnt_q + BW'(1);
        end
      end
      S_HIGH: begin
        if (div_end) begin
          sclk_d = 1'b0;
          if (bit_cnt_q != BITS) begin
            tx_shift_d = tx_shift_q << 1;
            mosi_d     = tx_shift_q[B-2];
          end
        end
      end
      S_HOLD: begin
        if (div_end) begin
          if (bit_cnt_q == BITS) begin
            bit_cnt_d = BITS_P1;
          end else begin
            cs_n_d     = 1'b1;
            mosi_d     = 1'b0;
            done_d     = 1'b1;
            rx_frame_d = rx_shift_q;
          end
        end
      end
      S_GAP: begin
        if (div_end) busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.rx_frame  = rx_frame_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_sclk  = sclk_q;
  assign bus.spi_mosi  = mosi_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_kstep_spi_host.sv
// Bench for kstep_spi_host: four instances cover D/N corners; a pin-level
// monitor and mode-0 responder check each frame against spec formulas.
module tb_kstep_spi_host;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_v   = 4'hF;
  logic [3:0]  start_v = 4'h0;
  logic [3:0]  miso_v  = 4'h0;
  logic [31:0] tx_v [4];

  logic [3:0]  cs_v, sclk_v, mosi_v, busy_v, done_v;
  logic [31:0] rx_v [4];

  // per-instance D and B
  int dval [4] = '{2, 1, 2, 3};
  int bval [4] = '{8, 32, 16, 8};

  kstep_spi_host_if #(.FRAME_BYTES(1)) if0 ();
  kstep_spi_host_if #(.FRAME_BYTES(4)) if1 ();
  kstep_spi_host_if #(.FRAME_BYTES(2)) if2 ();
  kstep_spi_host_if #(.FRAME_BYTES(1)) if3 ();

  kstep_spi_host #(.CLK_DIV(2), .FRAME_BYTES(1)) u0 (.clk(clk), .rst(rst_v[0]), .bus(if0.slave));
  kstep_spi_host #(.CLK_DIV(1), .FRAME_BYTES(4)) u1 (.clk(clk), .rst(rst_v[1]), .bus(if1.slave));
  kstep_spi_host #(.CLK_DIV(2), .FRAME_BYTES(2)) u2 (.clk(clk), .rst(rst_v[2]), .bus(if2.slave));
  kstep_spi_host #(.CLK_DIV(3), .FRAME_BYTES(1)) u3 (.clk(clk), .rst(rst_v[3]), .bus(if3.slave));

  assign if0.start = start_v[0]; assign if0.tx_frame = tx_v[0][7:0];  assign if0.spi_miso = miso_v[0];
  assign if1.start = start_v[1]; assign if1.tx_frame = tx_v[1];       assign if1.spi_miso = miso_v[1];
  assign if2.start = start_v[2]; assign if2.tx_frame = tx_v[2][15:0]; assign if2.spi_miso = miso_v[2];
  assign if3.start = start_v[3]; assign if3.tx_frame = tx_v[3][7:0];  assign if3.spi_miso = miso_v[3];

  assign cs_v   = {if3.spi_cs_n, if2.spi_cs_n, if1.spi_cs_n, if0.spi_cs_n};
  assign sclk_v = {if3.spi_sclk, if2.spi_sclk, if1.spi_sclk, if0.spi_sclk};
  assign mosi_v = {if3.spi_mosi, if2.spi_mosi, if1.spi_mosi, if0.spi_mosi};
  assign busy_v = {if3.busy, if2.busy, if1.busy, if0.busy};
  assign done_v = {if3.done, if2.done, if1.done, if0.done};
  assign rx_v[0] = 32'(if0.rx_frame);
  assign rx_v[1] = if1.rx_frame;
  assign rx_v[2] = 32'(if2.rx_frame);
  assign rx_v[3] = 32'(if3.rx_frame);

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int b);
    logic [31:0] one;
    one = 32'd1;
    return (b >= 32) ? 32'hFFFF_FFFF : ((one << b) - 32'd1);
  endfunction

  // ---------------- pin monitor / responder model ----------------
  int          sel;
  int          miso_mode;   // 0: miso low, 1: loop mosi, 2: mode-0 responder
  int          cyc, rise_cnt, cs_low_cnt, busy_cnt, done_cnt, cs_fall_cnt;
  int          last_fall, min_gap, max_gap, hi_run, min_hi_run;
  logic [31:0] mosi_bits, resp_sh, done_rx;
  logic        prev_sclk, prev_cs;

  task automatic clear_mon();
    cyc = 0; rise_cnt = 0; cs_low_cnt = 0; busy_cnt = 0; done_cnt = 0;
    cs_fall_cnt = 0; last_fall = 0; min_gap = 1 << 30; max_gap = 0;
    hi_run = 0; min_hi_run = 1 << 30;
    mosi_bits = '0; done_rx = '0;
    prev_sclk = 1'b0; prev_cs = 1'b1;
  endtask

  // One clock: sample selected instance at negedge, then update its miso.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (sclk_v[sel] && !prev_sclk) begin
      rise_cnt++;
      mosi_bits = {mosi_bits[30:0], mosi_v[sel]};
    end
    if (!cs_v[sel]) cs_low_cnt++;
    else            hi_run++;
    if (!cs_v[sel] && prev_cs) begin
      if (cs_fall_cnt > 0) begin
        if (cyc - last_fall < min_gap) min_gap = cyc - last_fall;
        if (cyc - last_fall > max_gap) max_gap = cyc - last_fall;
        if (hi_run < min_hi_run) min_hi_run = hi_run;
      end
      cs_fall_cnt++;
      last_fall = cyc;
      hi_run = 0;
    end
    if (busy_v[sel]) busy_cnt++;
    if (done_v[sel]) begin
      done_cnt++;
      done_rx = rx_v[sel];
    end
    case (miso_mode)
      1: miso_v[sel] = mosi_v[sel];
      2: if (!cs_v[sel] && (prev_cs || (prev_sclk && !sclk_v[sel]))) begin
           miso_v[sel] = resp_sh[31];
           resp_sh = resp_sh << 1;
         end
      default: miso_v[sel] = 1'b0;
    endcase
    prev_sclk = sclk_v[sel];
    prev_cs   = cs_v[sel];
  endtask

  task automatic begin_frame(input int d, input logic [31:0] tx, input logic [31:0] resp, input int mode);
    sel = d;
    clear_mon();
    miso_mode = mode;
    resp_sh = resp << (32 - bval[d]);
    tx_v[d] = tx;
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
    tx_v[d] = $urandom();
  endtask

  task automatic wait_idle(input int d);
    int budget;
    budget = dval[d] * (2 * bval[d] + 3) + 20;
    for (int i = 0; i < budget && busy_v[d]; i++) step();
    check("busy_timeout", 32'(busy_v[d]), 32'd0);
    step();
    step();
  endtask

  task automatic run_frame(input int d, input logic [31:0] tx, input logic [31:0] resp, input int mode);
    begin_frame(d, tx, resp, mode);
    wait_idle(d);
  endtask

  // Expected frame results come straight from the frame rules.
  task automatic check_frame(input int d, input logic [31:0] tx, input logic [31:0] exp_rx);
    int dd, bb;
    dd = dval[d];
    bb = bval[d];
    check("rx_frame",   rx_v[d],          exp_rx);
    check("rx_at_done", done_rx,          exp_rx);
    check("mosi_bits",  mosi_bits,        tx & mask_of(bb));
    check("sclk_rises", 32'(rise_cnt),    32'(bb));
    check("cs_low_cyc", 32'(cs_low_cnt),  32'(dd * (2 * bb + 2)));
    check("busy_cyc",   32'(busy_cnt),    32'(dd * (2 * bb + 3)));
    check("done_count", 32'(done_cnt),    32'd1);
    check("cs_falls",   32'(cs_fall_cnt), 32'd1);
  endtask

  typedef struct {
    int          dut;
    logic [31:0] tx;
    logic [31:0] resp;
    int          mode;
    logic [31:0] exp_rx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] tx, rs;
    int d;
    bit gap_pulsed;

    vecs[0] = '{0, 32'h0000_00A5, 32'h0,         1, 32'h0000_00A5};
    vecs[1] = '{1, 32'h1234_5678, 32'h0,         0, 32'h0};
    vecs[2] = '{2, 32'h0000_BEEF, 32'h0000_C001, 2, 32'h0000_C001};
    vecs[3] = '{3, 32'h0000_0081, 32'h0000_007E, 2, 32'h0000_007E};
    vecs[4] = '{1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF};
    vecs[5] = '{0, 32'h0000_005A, 32'h0000_003C, 2, 32'h0000_003C};
    for (int i = 0; i < 4; i++) tx_v[i] = '0;
    sel = 0;
    miso_mode = 0;
    clear_mon();

    // reset
    repeat (3) @(negedge clk);
    rst_v = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_cs_n", 32'(cs_v[i]),   32'd1);
      check("rst_sclk", 32'(sclk_v[i]), 32'd0);
      check("rst_mosi", 32'(mosi_v[i]), 32'd0);
      check("rst_busy", 32'(busy_v[i]), 32'd0);
      check("rst_done", 32'(done_v[i]), 32'd0);
      check("rst_rx",   rx_v[i],        32'd0);
    end

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].dut, vecs[i].tx, vecs[i].resp, vecs[i].mode);
      check_frame(vecs[i].dut, vecs[i].tx, vecs[i].exp_rx);
    end

    // rx_frame holds across idle time and through the next frame until done
    sel = 0;
    repeat (10) step();
    check("rx_hold_idle", rx_v[0], 32'h3C);
    begin_frame(0, 32'h0F, 32'hC3, 2);
    repeat (20) step();
    check("rx_hold_busy", rx_v[0], 32'h3C);
    wait_idle(0);
    check_frame(0, 32'h0F, 32'hC3);

    // start re-pulsed while busy and in GAP is ignored
    begin_frame(0, 32'h66, 32'h99, 2);
    gap_pulsed = 1'b0;
    for (int i = 0; i < 60 && busy_v[0]; i++) begin
      step();
      start_v[0] = 1'b0;
      if (busy_cnt == 5 && busy_v[0] && cs_low_cnt == 5) start_v[0] = 1'b1;
      if (cs_v[0] && busy_v[0] && cs_low_cnt > 0 && !gap_pulsed) begin
        start_v[0] = 1'b1;
        gap_pulsed = 1'b1;
      end
    end
    start_v[0] = 1'b0;
    repeat (10) step();
    check("ign_gap_seen",  32'(gap_pulsed),  32'd1);
    check("ign_done_cnt",  32'(done_cnt),    32'd1);
    check("ign_cs_falls",  32'(cs_fall_cnt), 32'd1);
    check("ign_cs_low",    32'(cs_low_cnt),  32'd36);
    check("ign_busy_cyc",  32'(busy_cnt),    32'd38);
    check("ign_rx",        rx_v[0],          32'h99);

    // reset mid-frame aborts without done
    begin_frame(2, 32'hF00D, 32'h5555, 2);
    for (int i = 0; i < 40 && busy_cnt < 10; i++) step();
    rst_v[2] = 1'b1;
    step();
    rst_v[2] = 1'b0;
    check("abort_cs_n", 32'(cs_v[2]),   32'd1);
    check("abort_sclk", 32'(sclk_v[2]), 32'd0);
    check("abort_busy", 32'(busy_v[2]), 32'd0);
    repeat (6) step();
    check("abort_done", 32'(done_cnt),  32'd0);
    check("abort_idle", 32'(busy_v[2]), 32'd0);
    run_frame(2, 32'h1234, 32'hA55A, 2);
    check_frame(2, 32'h1234, 32'hA55A);

    // start held high: back-to-back frames
    sel = 3;
    clear_mon();
    miso_mode = 0;
    tx_v[3] = 32'h96;
    start_v[3] = 1'b1;
    repeat (100) step();
    start_v[3] = 1'b0;
    for (int i = 0; i < 80 && busy_v[3]; i++) step();
    step();
    check("held_frames",   32'(cs_fall_cnt),      32'd2);
    check("held_done_cnt", 32'(done_cnt),         32'd2);
    check("held_min_gap",  32'(min_gap),          32'(3 * 19 + 1));
    check("held_max_gap",  32'(max_gap),          32'(3 * 19 + 1));
    check("held_cs_high",  32'(min_hi_run >= 3),  32'd1);

    // randomized frames against the frame rules
    for (int i = 0; i < 10; i++) begin
      d  = $urandom_range(0, 3);
      tx = $urandom();
      rs = $urandom();
      run_frame(d, tx, rs, 2);
      check_frame(d, tx, rs & mask_of(bval[d]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
